// File: rtl/piso_bit_feeder_pkg.sv
// Shared constants for the serial feeder and the run-detect FSM it drives.
// Keeping IDLE_BIT here keeps both sides in agreement on the idle line level.
package piso_bit_feeder_pkg;

   localparam logic StIdle  = 1'b0;
   localparam logic StShift = 1'b1;

   localparam int unsigned DEFAULT_WIDTH    = 8;
   localparam bit          DEFAULT_IDLE_BIT = 1'b0;

endpackage

// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out bit feeder with a one-word holding slot.
// Emits one bit per clock with no gap between consecutive words.
module piso_bit_feeder
   import piso_bit_feeder_pkg::*;
#(
   parameter int unsigned WIDTH     = DEFAULT_WIDTH,
   parameter bit          MSB_FIRST = 1'b1,
   parameter bit          IDLE_BIT  = DEFAULT_IDLE_BIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             w_out,
   output logic             w_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic             state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic             hold_valid_q, hold_valid_d;
   logic [WIDTH-1:0] hold_data_q, hold_data_d;

   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] shreg_shifted;

   assign in_ready = !hold_valid_q;
   assign accept   = in_valid && in_ready;
   assign last_bit = (bitcnt_q == LAST_BIT);

   assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bitcnt_d     = bitcnt_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;

      if (state_q == StIdle) begin
         if (accept) begin
            shreg_d  = in_data;
            bitcnt_d = '0;
            state_d  = StShift;
         end
      end else if (!last_bit) begin
         shreg_d  = shreg_shifted;
         bitcnt_d = bitcnt_q + CW'(1);
         if (accept) begin
            hold_data_d  = in_data;
            hold_valid_d = 1'b1;
         end
      end else begin
         // Last bit: reload from hold first, then bypass, so the next word follows with no gap.
         bitcnt_d = '0;
         if (hold_valid_q) begin
            shreg_d      = hold_data_q;
            hold_valid_d = 1'b0;
         end else if (accept) begin
            shreg_d = in_data;
         end else begin
            shreg_d = shreg_shifted;
            state_d = StIdle;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         shreg_q      <= '0;
         bitcnt_q     <= '0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bitcnt_q     <= bitcnt_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
      end
   end

   assign w_valid   = (state_q == StShift);
   assign w_out     = w_valid ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_BIT;
   assign word_done = w_valid && last_bit;
   assign busy      = w_valid || hold_valid_q;

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Bench for piso_bit_feeder: a bit-queue model checked every cycle, plus
// directed vectors with literal expectations for both bit orders.
module tb_piso_bit_feeder;

   logic       clk;
   logic       rst;
   logic       va, vb;
   logic [7:0] da, db;
   logic       ra, wa, wva, wda, ba;
   logic       rb, wb, wvb, wdb, bb;

   int checks = 0;
   int errors = 0;

   piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (va),
      .in_ready  (ra),
      .in_data   (da),
      .w_out     (wa),
      .w_valid   (wva),
      .word_done (wda),
      .busy      (ba)
   );

   piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (vb),
      .in_ready  (rb),
      .in_data   (db),
      .w_out     (wb),
      .w_valid   (wvb),
      .word_done (wdb),
      .busy      (bb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: queue of pending serial bits, each tagged with whether it ends its word.
   // The feeder holds at most two words (one shifting, one held).
   typedef struct packed {
      logic b;
      logic last;
   } mbit_t;

   mbit_t qa[$];
   mbit_t qb[$];
   int    na = 0;
   int    nb = 0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         qa.delete();
         qb.delete();
         na = 0;
         nb = 0;
      end else begin
         automatic bit acc_a = va && (na < 2);
         automatic bit acc_b = vb && (nb < 2);
         if (qa.size() > 0) begin
            if (qa[0].last) na--;
            void'(qa.pop_front());
         end
         if (qb.size() > 0) begin
            if (qb[0].last) nb--;
            void'(qb.pop_front());
         end
         if (acc_a) begin
            for (int i = 0; i < 8; i++) qa.push_back('{b: da[7-i], last: (i == 7)});
            na++;
         end
         if (acc_b) begin
            for (int i = 0; i < 8; i++) qb.push_back('{b: db[i], last: (i == 7)});
            nb++;
         end
      end
   end

   always @(negedge clk) begin
      automatic bit ev_a = (qa.size() > 0);
      automatic bit ev_b = (qb.size() > 0);
      check("model_a w_valid",   32'(wva), 32'(ev_a));
      check("model_a w_out",     32'(wa),  32'(ev_a ? qa[0].b : 1'b0));
      check("model_a word_done", 32'(wda), 32'(ev_a && qa[0].last));
      check("model_a busy",      32'(ba),  32'(ev_a));
      check("model_a in_ready",  32'(ra),  32'(na < 2));
      check("model_b w_valid",   32'(wvb), 32'(ev_b));
      check("model_b w_out",     32'(wb),  32'(ev_b ? qb[0].b : 1'b1));
      check("model_b word_done", 32'(wdb), 32'(ev_b && qb[0].last));
      check("model_b busy",      32'(bb),  32'(ev_b));
      check("model_b in_ready",  32'(rb),  32'(nb < 2));
   end

   // Directed stimulus tables and per-cycle captures.
   logic       sv[32];
   logic [7:0] sd[32];
   logic       gw[32], gv[32], gd[32], gr[32], gb[32];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stim();
      for (int i = 0; i < 32; i++) begin
         sv[i] = 1'b0;
         sd[i] = 8'h00;
      end
   endtask

   // Called just after a rising edge; cycle 0 is the cycle that starts now.
   task automatic run_seq(input int n, input bit sel_b);
      for (int c = 0; c < n; c++) begin
         if (sel_b) begin
            vb = sv[c];
            db = sd[c];
         end else begin
            va = sv[c];
            da = sd[c];
         end
         @(negedge clk);
         gw[c] = sel_b ? wb  : wa;
         gv[c] = sel_b ? wvb : wva;
         gd[c] = sel_b ? wdb : wda;
         gr[c] = sel_b ? rb  : ra;
         gb[c] = sel_b ? bb  : ba;
         tick();
      end
      va = 1'b0;
      vb = 1'b0;
   endtask

   // which: 0 w_out, 1 w_valid, 2 word_done, 3 in_ready, 4 busy
   function automatic logic [31:0] pack(input int lo, input int hi, input int which);
      logic [31:0] r = '0;
      for (int i = lo; i <= hi; i++) begin
         logic b;
         case (which)
            0: b = gw[i];
            1: b = gv[i];
            2: b = gd[i];
            3: b = gr[i];
            default: b = gb[i];
         endcase
         r = {r[30:0], b};
      end
      return r;
   endfunction

   initial begin
      rst = 1'b0;
      va  = 1'b0;
      vb  = 1'b0;
      da  = 8'h00;
      db  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("reset in_ready", 32'(ra), 32'h1);
      check("reset w_out_b idle", 32'(wb), 32'h1);
      rst = 1'b1;
      tick();

      // Idle for 20 cycles.
      clear_stim();
      run_seq(20, 1'b0);
      check("idle w_valid", pack(0, 19, 1), 32'h0);
      check("idle w_out", pack(0, 19, 0), 32'h0);
      check("idle word_done", pack(0, 19, 2), 32'h0);
      check("idle busy", pack(0, 19, 4), 32'h0);
      check("idle in_ready", pack(0, 19, 3), 32'hFFFFF);

      // Single word F0, MSB first.
      clear_stim();
      sv[0] = 1'b1; sd[0] = 8'hF0;
      run_seq(11, 1'b0);
      check("f0 bits", pack(1, 8, 0), 32'hF0);
      check("f0 w_valid", pack(1, 8, 1), 32'hFF);
      check("f0 word_done", pack(1, 8, 2), 32'h01);
      check("f0 first latency", 32'(gv[0]), 32'h0);
      check("f0 after valid", 32'(gv[9]), 32'h0);
      check("f0 after w_out", 32'(gw[9]), 32'h0);

      // Back-to-back AA, 0F, then 33 held valid until taken.
      clear_stim();
      sv[0] = 1'b1; sd[0] = 8'hAA;
      sv[1] = 1'b1; sd[1] = 8'h0F;
      for (int c = 2; c <= 9; c++) begin
         sv[c] = 1'b1;
         sd[c] = 8'h33;
      end
      run_seq(27, 1'b0);
      check("b2b ready c1", 32'(gr[1]), 32'h1);
      check("b2b ready low 2..8", pack(2, 8, 3), 32'h0);
      check("b2b ready c9", 32'(gr[9]), 32'h1);
      check("b2b bits", pack(1, 24, 0), 32'hAA0F33);
      check("b2b w_valid", pack(1, 24, 1), 32'hFFFFFF);
      check("b2b word_done", pack(1, 24, 2), 32'h010101);
      check("b2b end", 32'(gv[25]), 32'h0);

      // Bypass: second word offered only on the last bit of the first.
      clear_stim();
      sv[0] = 1'b1; sd[0] = 8'hFF;
      sv[8] = 1'b1; sd[8] = 8'h00;
      run_seq(19, 1'b0);
      check("bypass bits", pack(1, 16, 0), 32'hFF00);
      check("bypass w_valid", pack(1, 16, 1), 32'hFFFF);
      check("bypass in_ready", pack(0, 16, 3), 32'h1FFFF);
      check("bypass end", 32'(gv[17]), 32'h0);

      // Asynchronous reset in the middle of a word.
      va = 1'b1; da = 8'hFF;
      tick();
      va = 1'b0;
      repeat (3) tick();
      check("rst pre valid", 32'(wva), 32'h1);
      #2;
      rst = 1'b0;
      #1;
      check("rst async w_valid", 32'(wva), 32'h0);
      check("rst async w_out", 32'(wa), 32'h0);
      check("rst async busy", 32'(ba), 32'h0);
      check("rst async in_ready", 32'(ra), 32'h1);
      tick();
      rst = 1'b1;
      clear_stim();
      sv[2] = 1'b1; sd[2] = 8'h81;
      run_seq(12, 1'b0);
      check("rst no residual", pack(0, 2, 1), 32'h0);
      check("rst in_ready", 32'(gr[0]), 32'h1);
      check("rst 81 bits", pack(3, 10, 0), 32'h81);
      check("rst 81 valid", pack(3, 10, 1), 32'hFF);
      check("rst 81 end", 32'(gv[11]), 32'h0);

      // LSB first with idle level 1.
      clear_stim();
      sv[0] = 1'b1; sd[0] = 8'h01;
      run_seq(11, 1'b1);
      check("lsb idle w_out", 32'(gw[0]), 32'h1);
      check("lsb bits", pack(1, 8, 0), 32'h80);
      check("lsb w_valid", pack(1, 8, 1), 32'hFF);
      check("lsb word_done", 32'(gd[8]), 32'h1);
      check("lsb after w_out", 32'(gw[9]), 32'h1);
      check("lsb after valid", 32'(gv[9]), 32'h0);

      repeat (2) tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
